// File: rtl/fb_arbiter.sv
// Frame-buffer RAM arbiter: scanner reads (priority) vs host writes, double-buffer swap.
// Ports: clk/rst_n; scan_* read side; wr_* host side; swap_req/swap_pending/front_buf; ram_*.
// Macro FB_STARVE_GUARD_EN: enables the host starvation counter and forced write grant.
module fb_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scan_req,
    input  logic [9:0]  scan_addr,
    output logic        scan_gnt,
    output logic        scan_valid,
    output logic [23:0] scan_data,
    input  logic        scan_frame_end,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [9:0]  wr_addr,
    input  logic [23:0] wr_data,
    input  logic        swap_req,
    output logic        swap_pending,
    output logic        front_buf,
    output logic [10:0] ram_addr,
    output logic        ram_we,
    output logic [23:0] ram_wdata,
    input  logic [23:0] ram_rdata
);

    logic force_wr;
    logic wr_xfer;
    logic rd_v1;

`ifdef FB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!wr_valid || wr_xfer) begin
            starve_cnt <= '0;
        end else if (scan_gnt && starve_cnt != LIM) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    assign force_wr = wr_valid && (starve_cnt == LIM);
`else
    assign force_wr = 1'b0;
`endif

    // Grants are gated by rst_n so nothing reaches the RAM while in reset.
    assign scan_gnt = rst_n & scan_req & ~force_wr;
    assign wr_ready = rst_n & ~scan_gnt;
    assign wr_xfer  = wr_valid & wr_ready;

    always_comb begin
        ram_addr  = {front_buf, scan_addr};
        ram_we    = 1'b0;
        ram_wdata = wr_data;
        if (wr_xfer) begin
            ram_addr = {~front_buf, wr_addr};
            ram_we   = 1'b1;
        end
    end

    // Stage 1 waits for RAM latency; stage 2 captures the returned word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1      <= 1'b0;
            scan_valid <= 1'b0;
            scan_data  <= '0;
        end else begin
            rd_v1      <= scan_gnt;
            scan_valid <= rd_v1;
            if (rd_v1) begin
                scan_data <= ram_rdata;
            end
        end
    end

    // A swap requested in the frame-end cycle itself takes effect at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_buf    <= 1'b0;
            swap_pending <= 1'b0;
        end else if (scan_frame_end && (swap_pending || swap_req)) begin
            front_buf    <= ~front_buf;
            swap_pending <= 1'b0;
        end else if (swap_req) begin
            swap_pending <= 1'b1;
        end
    end

endmodule
